regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// Shares the single register-file write port (reg_dest/data/regWEn) between NUM_REQ writeback sources
// (e.g. ALU and load unit) by round-robin arbitration. Registers the winning write, 1 cycle, into the
// regfile. Keeps a pending-write scoreboard so decode can stall on RAW hazards against outstanding writes.
// Sits between the writeback sources and the 32x32 regfile.
// PARAMETERS
// NUM_REQ  2   number of writeback requesters (>=2)
// XLEN     32  data width
// NREGS    32  architectural registers; register 0 is hardwired zero
// AW       5   register index width, clog2(NREGS)
// PORTS
// clk        in   1            clock, all state on posedge
// rst        in   1            synchronous reset, active-high
// req_valid  in   NUM_REQ      requester i has a write
// req_dest   in   NUM_REQ*AW   dest of requester i at [i*AW +: AW]
// req_data   in   NUM_REQ*XLEN data of requester i at [i*XLEN +: XLEN]
// req_ready  out  NUM_REQ      one-hot grant; transfer when valid&ready
// hold       in   1            1 = grant nothing this cycle
// wb_dest    out  AW           to regfile reg_dest
// wb_data    out  XLEN         to regfile data
// wb_en      out  1            to regfile regWEn
// iss_valid  in   1            decode issues an instr that will write iss_dest
// iss_dest   in   AW           dest of issued instr
// chk_a      in   AW           source A index to check
// chk_b      in   AW           source B index to check
// busy_a     out  1            pending[chk_a] (combinational)
// busy_b     out  1            pending[chk_b] (combinational)
// idle       out  1            no pending bits and wb_en==0
// BEHAVIOUR
// - Reset: wb_en=0, wb_dest=0, wb_data=0, pending=0, rr pointer=0. req_ready=0 while rst=1.
// - Arbitration: search starts at pointer p and wraps mod NUM_REQ; the first valid requester wins.
//   req_ready is combinational, at most one bit set, and gated by !hold && !rst. Never depends on ready.
// - Pointer: after a grant to i, p <= (i+1) mod NUM_REQ. Unchanged when nothing is granted or hold=1.
// - Output: on a grant, the next edge loads wb_dest/wb_data from the winner and sets wb_en=1.
//   Otherwise wb_en <= 0 and wb_dest/wb_data hold.
//   Latency: accept in cycle N -> regfile writes at the end of cycle N+1. Throughput 1 write/cycle.
// - x0: a grant with dest 0 is consumed (ready=1) but wb_en <= 0.
// - Scoreboard: pending[NREGS] bits.
//   - Set at the edge when iss_valid && iss_dest!=0.
//   - Cleared at the edge when wb_en && wb_dest!=0; the regfile commits on the same edge.
//   - Same reg set and cleared together: set wins.
//   - pending[0] is constant 0. busy_x = pending[chk_x].
// - Hazard timing: after the clearing edge, busy=0 and a regfile read returns the new data. No bypass here.
// - Two writes to the same dest in consecutive grants both commit in grant order; the first clears pending.
// - Mid-operation reset: an in-flight wb_en is dropped (the regfile is reset too) and all pending bits clear.
// STRUCTURE
// - regfile_pkg: XLEN, NREGS, AW constants, shared with the regfile and decode.
// - Sub-module rr_arbiter #(N): req, advance -> one-hot grant and pointer.
//   Used once here, reusable for read-port sharing.
// - Top level: arbiter, data mux, output register stage, scoreboard vector.
// TESTING
// 1 Reset: assert rst with pending bits set -> next cycle wb_en=0, pending=0, idle=1, req_ready=0.
// 2 Round-robin: req_valid=2'b11 for 4 cycles, dests 3/7 -> grants 0,1,0,1; wb_en every cycle,
//   wb_dest 3,7,3,7 each one cycle after its grant.
// 3 Hold: req_valid=2'b01 with hold=1 for 3 cycles -> req_ready=0 and wb_en=0; pointer is unchanged afterwards.
// 4 x0: requester 1 dest=0 data=32'hDEAD -> req_ready[1]=1, wb_en stays 0, regfile x0 reads 0.
// 5 Scoreboard: iss x5, then chk_a=5 -> busy_a=1 until the edge with wb_en&&wb_dest==5, then 0.
//   iss x5 again on that same edge -> busy_a stays 1.
// 6 Reset mid-flight: grant in cycle N, rst in cycle N+1 -> no write to the regfile, idle=1 after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_pkg : register-file geometry shared by regfile, decode, writeback |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xword_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : round-robin arbiter, one-hot grant plus winner index         |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] win
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  // Search starts at the pointer and wraps; lowest offset from the pointer wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    grant = (advance && found) ? (N'(1) << win) : '0;
    ptr_d = ptr_q;
    if (advance && found) ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter : shares the regfile write port among writeback units  |
// |                      and tracks outstanding writes for RAW stalls         |
// | Revision           : 1.0                                                  |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = regfile_pkg::XLEN,
  parameter int NREGS   = regfile_pkg::NREGS,
  parameter int AW      = regfile_pkg::AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*AW-1:0]   req_dest,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    hold,
  output logic [AW-1:0]           wb_dest,
  output logic [XLEN-1:0]         wb_data,
  output logic                    wb_en,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_dest,
  input  logic [AW-1:0]           chk_a,
  input  logic [AW-1:0]           chk_b,
  output logic                    busy_a,
  output logic                    busy_b,
  output logic                    idle
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      win;
  logic [AW-1:0]      sel_dest;
  logic [XLEN-1:0]    sel_data;
  logic               any_grant;

  logic [AW-1:0]      wb_dest_q, wb_dest_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic               wb_en_q,   wb_en_d;
  logic [NREGS-1:0]   pending_q, pending_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (!hold && !rst),
    .grant   (grant),
    .win     (win)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign sel_dest  = req_dest[int'(win)*AW +: AW];
  assign sel_data  = req_data[int'(win)*XLEN +: XLEN];

  // A grant to x0 is consumed but never reaches the regfile.
  always_comb begin
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;
    wb_en_d   = 1'b0;
    if (any_grant) begin
      wb_dest_d = sel_dest;
      wb_data_d = sel_data;
      wb_en_d   = (sel_dest != '0);
    end
  end

  // Issue set is applied after the commit clear so a same-edge re-issue stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_en_q && wb_dest_q != '0) pending_d[wb_dest_q] = 1'b0;
    if (iss_valid && iss_dest != '0) pending_d[iss_dest] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_dest_q <= '0;
      wb_data_q <= '0;
      wb_en_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
      wb_en_q   <= wb_en_d;
      pending_q <= pending_d;
    end
  end

  assign wb_dest = wb_dest_q;
  assign wb_data = wb_data_q;
  assign wb_en   = wb_en_q;
  assign busy_a  = pending_q[chk_a];
  assign busy_b  = pending_q[chk_b];
  assign idle    = (pending_q == '0) && !wb_en_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter : directed bench with a write scoreboard            |
// | Revision              : 1.0                                               |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;
  localparam int AW      = 5;

  typedef struct packed {
    logic [AW-1:0]   dest;
    logic [XLEN-1:0] data;
    int              cyc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*AW-1:0]   req_dest;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    hold;
  logic [AW-1:0]           wb_dest;
  logic [XLEN-1:0]         wb_data;
  logic                    wb_en;
  logic                    iss_valid;
  logic [AW-1:0]           iss_dest;
  logic [AW-1:0]           chk_a;
  logic [AW-1:0]           chk_b;
  logic                    busy_a;
  logic                    busy_b;
  logic                    idle;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .NREGS(32), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .wb_en     (wb_en),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .chk_a     (chk_a),
    .chk_b     (chk_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .idle      (idle)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // A grant seen in this cycle must appear on the write port during the next cycle.
  task automatic push(input logic [AW-1:0] d, input logic [XLEN-1:0] v);
    exp_t e;
    e.dest = d;
    e.data = v;
    e.cyc  = cyc_cnt + 1;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writes taken while rst is high are discarded by the regfile, so they are not committed.
  always @(negedge clk) begin
    if (!rst && wb_en) begin
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got dest %0d data %0h, expected no write", wb_dest, wb_data);
      end else begin
        e = sb.pop_front();
        if (wb_dest !== e.dest || wb_data !== e.data || cyc_cnt != e.cyc) begin
          n_err++;
          $display("FAIL wb_write: got dest %0d data %0h cyc %0d, expected dest %0d data %0h cyc %0d",
                   wb_dest, wb_data, cyc_cnt, e.dest, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_dest = '0; req_data = '0; hold = 1'b0;
    iss_valid = 1'b0; iss_dest = '0; chk_a = '0; chk_b = '0;
    repeat (3) step();

    // Reset with pending bits set
    rst = 1'b0; iss_valid = 1'b1; iss_dest = 5'd5;
    step(); iss_dest = 5'd9;
    step(); iss_valid = 1'b0; chk_a = 5'd5; chk_b = 5'd9;
    #1; chk("busy_a_set", busy_a, 1); chk("busy_b_set", busy_b, 1); chk("idle_busy", idle, 0);
    step(); rst = 1'b1; req_valid = 2'b11; req_dest = {5'd7, 5'd3};
    #1; chk("ready_in_rst", req_ready, 2'b00);
    step(); rst = 1'b0; req_valid = 2'b00;
    #1; chk("rst_busy_a", busy_a, 0); chk("rst_busy_b", busy_b, 0);
    chk("rst_idle", idle, 1); chk("rst_wb_en", wb_en, 0);

    // Round-robin with both requesters active
    for (int k = 0; k < 4; k++) begin
      step(); req_valid = 2'b11; req_dest = {5'd7, 5'd3};
      req_data = {32'hB000_0000 + k, 32'hA000_0000 + k};
      #1;
      if (k % 2 == 0) begin
        chk("rr_ready", req_ready, 2'b01); push(5'd3, 32'hA000_0000 + k);
      end else begin
        chk("rr_ready", req_ready, 2'b10); push(5'd7, 32'hB000_0000 + k);
      end
    end

    // Hold blocks grants and leaves the pointer alone
    for (int k = 0; k < 3; k++) begin
      step(); req_valid = 2'b01; hold = 1'b1;
      #1; chk("hold_ready", req_ready, 2'b00);
    end
    step(); hold = 1'b0; req_valid = 2'b11; req_data = {32'hB000_0010, 32'hA000_0010};
    #1; chk("post_hold_ready", req_ready, 2'b01); push(5'd3, 32'hA000_0010);

    // x0 write is consumed but suppressed
    step(); req_valid = 2'b10; req_dest = {5'd0, 5'd3}; req_data = {32'hDEAD, 32'h0};
    #1; chk("x0_ready", req_ready, 2'b10);
    step(); req_valid = 2'b00;
    #1; chk("x0_wb_en", wb_en, 0);

    // Scoreboard set / clear, x0 never pending, same-edge re-issue
    step(); iss_valid = 1'b1; iss_dest = 5'd5; chk_a = 5'd5;
    step(); iss_valid = 1'b0; req_valid = 2'b01; req_dest = {5'd0, 5'd5}; req_data = {32'h0, 32'h5555_0001};
    #1; chk("sb_busy_pre", busy_a, 1); chk("sb_ready1", req_ready, 2'b01); push(5'd5, 32'h5555_0001);
    step(); req_valid = 2'b00;
    #1; chk("sb_busy_wb", busy_a, 1);
    step(); iss_valid = 1'b1; iss_dest = 5'd0; chk_b = 5'd0;
    #1; chk("sb_busy_clr", busy_a, 0);
    step(); iss_dest = 5'd5;
    #1; chk("sb_x0_busy", busy_b, 0);
    step(); iss_valid = 1'b0; req_valid = 2'b01; req_data = {32'h0, 32'h5555_0002};
    #1; chk("sb_busy2", busy_a, 1); chk("sb_ready2", req_ready, 2'b01); push(5'd5, 32'h5555_0002);
    step(); req_valid = 2'b00; iss_valid = 1'b1; iss_dest = 5'd5;
    #1; chk("sb_busy_wb2", busy_a, 1);
    step(); iss_valid = 1'b0;
    #1; chk("sb_set_wins", busy_a, 1);
    step(); req_valid = 2'b01; req_data = {32'h0, 32'h5555_0003};
    #1; chk("sb_ready3", req_ready, 2'b01); push(5'd5, 32'h5555_0003);
    step(); req_valid = 2'b00;
    #1; chk("sb_busy_wb3", busy_a, 1);
    step();
    #1; chk("sb_busy_final", busy_a, 0); chk("sb_idle", idle, 1);

    // Reset while a write is in flight
    step(); req_valid = 2'b01; req_dest = {5'd0, 5'd12}; req_data = {32'h0, 32'hC0C0_C0C0};
    iss_valid = 1'b1; iss_dest = 5'd12;
    #1; chk("mf_ready", req_ready, 2'b01);
    step(); rst = 1'b1; req_valid = 2'b00; iss_valid = 1'b0;
    #1; chk("mf_ready_rst", req_ready, 2'b00);
    step(); rst = 1'b0;
    #1; chk("mf_wb_en", wb_en, 0); chk("mf_idle", idle, 1);

    repeat (2) step();
    chk("sb_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
